id_queue_stage: RTL and testbench
=================================

Name: id_queue_stage

Overview:
Parametrised successor to the combinational decode stage. It places a DEPTH-entry instruction queue between IF and decode, decodes the queue head, and registers the decoded bundle into a valid/ready output slot feeding EX. Fetch runs ahead of decode, backpressure from EX is absorbed, and a flush port discards all in-flight instructions on redirect, trap or mret.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
PC_W, 32, program-counter width carried with each instruction
CNT_W, $clog2(DEPTH)+1, width of occupancy count

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  IF presents instruction
in_ready  out  1  queue can accept
in_ir  in  32  instruction word
in_pc  in  PC_W  instruction address
flush  in  1  discard queue and output slot
out_valid  out  1  decoded bundle valid
out_ready  in  1  EX accepts bundle
out_pc  out  PC_W  pc of bundle
out_ir  out  32  raw instruction
out_rs1, out_rs2, out_rd  out  5 each  register fields ir[19:15], ir[24:20], ir[11:7]
out_opcode  out  7  ir[6:0]
out_funct3  out  3  ir[14:12]
out_funct7  out  7  ir[31:25]
out_imm  out  32  extracted immediate
out_wr_reg_n  out  1  0 = write rd, 1 = no write
out_is_illegal_ir  out  1  1 = illegal
count  out  CNT_W  queue occupancy (output slot excluded)

Behaviour:
- Reset (sync, rst=1 at edge): queue empty, head/tail pointers 0, count=0, out_valid=0, all out_* data = 0. Reset wins over flush and push.
- Push when in_valid && in_ready. in_ready = (count != DEPTH), from registered count only; no combinational path from out_ready.
- Slot load condition: queue non-empty && (!out_valid || out_ready). On load, head pops and its decode is registered into the slot.
- Output slot holds while out_valid && !out_ready. All out_* are stable during a stall.
- Transfer occurs on out_valid && out_ready. If no load happens in the same cycle, out_valid drops.
- Latency: an accepted instruction reaches the slot no earlier than the edge after the push. There is no queue bypass, so minimum is 2 edges from in_valid to out_valid.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- Flush at edge: count=0, pointers=0, out_valid=0. A push in the same cycle is dropped. An out transfer in the same cycle is considered taken by EX.
- Decode (combinational on queue head):
  - Immediates:
    - U: {ir[31:12],12'b0}
    - J: sext {ir[31],ir[19:12],ir[20],ir[30:21],0}
    - I (JALR, LOAD, OP-IMM except shifts): sext ir[31:20]
    - shamt (OP-IMM funct3 001/101): {27'b0, ir[24:20]}
    - B: sext {ir[31],ir[7],ir[30:25],ir[11:8],0}
    - S: sext {ir[31:25],ir[11:7]}
    - SYSTEM: {27'b0, ir[19:15]}
    - other opcodes: 0
  - Illegal:
    - unsupported opcode
    - JALR funct3 != 000
    - BRANCH funct3 010/011
    - LOAD funct3 011/110/111
    - STORE funct3 > 010
    - SLLI funct7 != 0
    - SRLI/SRAI funct7 not 0 or 0100000
    - R-type: funct7 not 0 or 0100000 for funct3 000/101, funct7 != 0 otherwise
    - SYSTEM funct3 100
    - SYSTEM funct3 000 unless ir is exactly ECALL (0x00000073) or MRET (0x30200073)
  - out_wr_reg_n = 0 only when all of: legal, rd != 0, and opcode is LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP, or SYSTEM with funct3 != 000.
- count never exceeds DEPTH or underflows. A push when full is impossible because in_ready=0.

Test Plan:
1. After reset, in_valid=1, in_ir=0x00500093 (addi x1,x0,5), out_ready=1 -> 2 edges later out_valid=1, out_rd=1, out_imm=5, out_wr_reg_n=0, out_is_illegal_ir=0.
2. Decode 0x12345137 -> out_imm=0x12345000, out_rd=2. Decode 0xFE000EE3 (beq -4) -> out_imm=0xFFFFFFFC, out_wr_reg_n=1.
3. 0xFFFFFFFF, then 0x00100073 (ebreak) -> both out_is_illegal_ir=1, out_wr_reg_n=1. Then 0x30200073 -> illegal=0.
4. DEPTH=4, out_ready=0, in_valid held with pc 0,4,8,... -> exactly 5 accepted, count=4, in_ready=0, out_pc=0 held. Raise out_ready -> out_pc sequence 0,4,8,12,16 with no loss or duplication.
5. Queue holding 3 plus valid slot, assert flush with in_valid=1 -> next cycle count=0, out_valid=0, the flushed-cycle push absent. Subsequent push appears normally.
6. Steady stream with in_valid=1, out_ready=1 for 20 cycles -> one bundle per cycle after fill, count constant, pointer wrap correct, pcs in order.

Source files
------------

// File: rtl/id_queue_stage.sv
// id_queue_stage: instruction queue between IF and decode, followed by a
// registered decode slot feeding EX.
//
// Handshake rules (both sides): a transfer happens on a rising edge where
// valid && ready are both high. A producer holding valid keeps its payload
// stable until the transfer. in_ready depends only on the registered
// occupancy, so there is no combinational path from out_ready to in_ready.
// flush discards every queued entry and the output slot. A push offered in
// the flush cycle is dropped. A slot transfer in the flush cycle counts as
// taken by EX.
module id_queue_stage #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ir,
  input  logic [PC_W-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [31:0]      out_ir,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [6:0]       out_opcode,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [31:0]      out_imm,
  output logic             out_wr_reg_n,
  output logic             out_is_illegal_ir,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [31:0] IR_ECALL = 32'h0000_0073;
  localparam logic [31:0] IR_MRET  = 32'h3020_0073;

  // Queue storage and pointers
  logic [31:0]      ir_mem_q [DEPTH];
  logic [PC_W-1:0]  pc_mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Output slot
  logic             out_valid_q;
  logic [PC_W-1:0]  out_pc_q;
  logic [31:0]      out_ir_q;
  logic [31:0]      out_imm_q;
  logic             out_wr_reg_n_q;
  logic             out_ill_q;

  logic push, load;

  // Decode of the queue head
  logic [31:0] hir;
  logic [6:0]  h_opc;
  logic [2:0]  h_f3;
  logic [6:0]  h_f7;
  logic [4:0]  h_rd;
  logic [31:0] dec_imm;
  logic        dec_ill;
  logic        dec_wr_en;
  logic        dec_wr_reg_n;

  assign in_ready = (count_q != CNT_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign load     = (count_q != '0) && (!out_valid_q || out_ready);

  assign hir   = ir_mem_q[head_q];
  assign h_opc = hir[6:0];
  assign h_f3  = hir[14:12];
  assign h_f7  = hir[31:25];
  assign h_rd  = hir[11:7];

  // Immediate extraction and legality check for the head instruction
  always_comb begin
    dec_imm   = '0;
    dec_ill   = 1'b0;
    dec_wr_en = 1'b0;
    case (h_opc)
      OP_LUI, OP_AUIPC: begin
        dec_imm   = {hir[31:12], 12'b0};
        dec_wr_en = 1'b1;
      end
      OP_JAL: begin
        dec_imm   = {{11{hir[31]}}, hir[31], hir[19:12], hir[20], hir[30:21], 1'b0};
        dec_wr_en = 1'b1;
      end
      OP_JALR: begin
        dec_imm   = {{20{hir[31]}}, hir[31:20]};
        dec_ill   = (h_f3 != 3'b000);
        dec_wr_en = 1'b1;
      end
      OP_BRANCH: begin
        dec_imm = {{19{hir[31]}}, hir[31], hir[7], hir[30:25], hir[11:8], 1'b0};
        dec_ill = (h_f3 == 3'b010) || (h_f3 == 3'b011);
      end
      OP_LOAD: begin
        dec_imm   = {{20{hir[31]}}, hir[31:20]};
        dec_ill   = (h_f3 == 3'b011) || (h_f3 == 3'b110) || (h_f3 == 3'b111);
        dec_wr_en = 1'b1;
      end
      OP_STORE: begin
        dec_imm = {{20{hir[31]}}, hir[31:25], hir[11:7]};
        dec_ill = (h_f3 > 3'b010);
      end
      OP_IMM: begin
        dec_wr_en = 1'b1;
        if (h_f3 == 3'b001) begin
          dec_imm = {27'b0, hir[24:20]};
          dec_ill = (h_f7 != 7'b0000000);
        end else if (h_f3 == 3'b101) begin
          dec_imm = {27'b0, hir[24:20]};
          dec_ill = !((h_f7 == 7'b0000000) || (h_f7 == 7'b0100000));
        end else begin
          dec_imm = {{20{hir[31]}}, hir[31:20]};
        end
      end
      OP_OP: begin
        dec_wr_en = 1'b1;
        if ((h_f3 == 3'b000) || (h_f3 == 3'b101)) begin
          dec_ill = !((h_f7 == 7'b0000000) || (h_f7 == 7'b0100000));
        end else begin
          dec_ill = (h_f7 != 7'b0000000);
        end
      end
      OP_SYSTEM: begin
        dec_imm = {27'b0, hir[19:15]};
        if (h_f3 == 3'b100) begin
          dec_ill = 1'b1;
        end else if (h_f3 == 3'b000) begin
          dec_ill = !((hir == IR_ECALL) || (hir == IR_MRET));
        end else begin
          dec_wr_en = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
  end

  assign dec_wr_reg_n = !(dec_wr_en && !dec_ill && (h_rd != 5'd0));

  // Pointer and occupancy next-state; flush clears everything
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push) tail_d = tail_q + PTR_W'(1);
      if (load) head_d = head_q + PTR_W'(1);
      case ({push, load})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage write; a push in a flush or reset cycle is dropped
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      ir_mem_q[tail_q] <= in_ir;
      pc_mem_q[tail_q] <= in_pc;
    end
  end

  // Output slot: load decoded head, hold on stall, drop after transfer
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_ir_q       <= '0;
      out_imm_q      <= '0;
      out_wr_reg_n_q <= 1'b0;
      out_ill_q      <= 1'b0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (load) begin
      out_valid_q    <= 1'b1;
      out_pc_q       <= pc_mem_q[head_q];
      out_ir_q       <= hir;
      out_imm_q      <= dec_imm;
      out_wr_reg_n_q <= dec_wr_reg_n;
      out_ill_q      <= dec_ill;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_pc            = out_pc_q;
  assign out_ir            = out_ir_q;
  assign out_rs1           = out_ir_q[19:15];
  assign out_rs2           = out_ir_q[24:20];
  assign out_rd            = out_ir_q[11:7];
  assign out_opcode        = out_ir_q[6:0];
  assign out_funct3        = out_ir_q[14:12];
  assign out_funct7        = out_ir_q[31:25];
  assign out_imm           = out_imm_q;
  assign out_wr_reg_n      = out_wr_reg_n_q;
  assign out_is_illegal_ir = out_ill_q;
  assign count             = count_q;

endmodule

// File: tb/tb_id_queue_stage.sv
// Bench for id_queue_stage: hand-decoded instruction table, occupancy model
// and an expected-bundle queue checked whenever the output slot is valid.
module tb_id_queue_stage;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int EW    = 98;  // {pc, ir, imm, ill, wrn}
  localparam int NT    = 24;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_ir = '0;
  logic [PC_W-1:0]  in_pc = '0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [PC_W-1:0]  out_pc;
  logic [31:0]      out_ir;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  logic [6:0]       out_opcode;
  logic [2:0]       out_funct3;
  logic [6:0]       out_funct7;
  logic [31:0]      out_imm;
  logic             out_wr_reg_n;
  logic             out_is_illegal_ir;
  logic [CNT_W-1:0] count;

  id_queue_stage #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ir(in_ir), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_ir(out_ir),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .out_imm(out_imm), .out_wr_reg_n(out_wr_reg_n),
    .out_is_illegal_ir(out_is_illegal_ir), .count(count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- instruction table (hand decoded) ----------------
  logic [31:0] tbl_ir [NT] = '{
    32'h00500093, 32'h12345137, 32'hFE000EE3, 32'hFFFFFFFF,
    32'h00100073, 32'h30200073, 32'h00000073, 32'h008000EF,
    32'h00409193, 32'h4040D193, 32'h40409193, 32'h0020A623,
    32'hFFC0A283, 32'h0000B283, 32'h402082B3, 32'h402092B3,
    32'h300092F3, 32'h0000C2F3, 32'h00000013, 32'h00001397,
    32'h000110E7, 32'h00002063, 32'h00003023, 32'h0240D193};
  logic [31:0] tbl_imm [NT] = '{
    32'h00000005, 32'h12345000, 32'hFFFFFFFC, 32'h00000000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000008,
    32'h00000004, 32'h00000004, 32'h00000004, 32'h0000000C,
    32'hFFFFFFFC, 32'h00000000, 32'h00000000, 32'h00000000,
    32'h00000001, 32'h00000001, 32'h00000000, 32'h00001000,
    32'h00000000, 32'h00000000, 32'h00000000, 32'h00000004};
  logic tbl_ill [NT] = '{
    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
    1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic tbl_wrn [NT] = '{
    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
    1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
    1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard and occupancy model ----------------
  logic [EW-1:0] exp_q[$];
  int            cur_idx   = 0;
  int            mdl_cnt   = 0;
  logic          mdl_ov    = 1'b0;
  int            dut_acc   = 0;
  int            delivered = 0;
  logic [31:0]   last_pc   = '0;

  always @(negedge clk) begin
    logic [EW-1:0] e;
    logic          ld, ps;
    if (rst) begin
      mdl_cnt = 0;
      mdl_ov  = 1'b0;
      exp_q.delete();
    end else begin
      check_val("count", 32'(count), 32'(mdl_cnt));
      check_val("out_valid", 32'(out_valid), 32'(mdl_ov));
      check_val("in_ready", 32'(in_ready), 32'(mdl_cnt != DEPTH));
      if (in_valid && in_ready && !flush) dut_acc++;
      if (mdl_ov) begin
        e = exp_q[0];
        check_val("out_pc", out_pc, e[97:66]);
        check_val("out_ir", out_ir, e[65:34]);
        check_val("out_imm", out_imm, e[33:2]);
        check_val("out_illegal", 32'(out_is_illegal_ir), 32'(e[1]));
        check_val("out_wr_reg_n", 32'(out_wr_reg_n), 32'(e[0]));
        check_val("out_rd", 32'(out_rd), 32'(e[45:41]));
        check_val("out_rs1", 32'(out_rs1), 32'(e[53:49]));
        check_val("out_rs2", 32'(out_rs2), 32'(e[58:54]));
        check_val("out_opcode", 32'(out_opcode), 32'(e[40:34]));
        check_val("out_funct3", 32'(out_funct3), 32'(e[48:46]));
        check_val("out_funct7", 32'(out_funct7), 32'(e[65:59]));
        if (out_ready) begin
          void'(exp_q.pop_front());
          delivered++;
          last_pc = e[97:66];
        end
      end
      ld = (mdl_cnt != 0) && (!mdl_ov || out_ready);
      ps = in_valid && (mdl_cnt != DEPTH);
      if (flush) begin
        mdl_cnt = 0;
        mdl_ov  = 1'b0;
        exp_q.delete();
      end else begin
        if (ps) exp_q.push_back({32'(in_pc), in_ir, tbl_imm[cur_idx], tbl_ill[cur_idx], tbl_wrn[cur_idx]});
        mdl_cnt = mdl_cnt + (ps ? 1 : 0) - (ld ? 1 : 0);
        if (ld) mdl_ov = 1'b1;
        else if (out_ready) mdl_ov = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input int idx, input logic [31:0] pc);
    cur_idx = idx;
    in_ir   = tbl_ir[idx];
    in_pc   = pc;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] pc;
    logic        acc;
    int          base_acc, base_del, guard;

    // Reset, with a push offered during reset that must be dropped
    set_instr(0, 32'h0);
    in_valid = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_ir", out_ir, 32'd0);
    check_val("rst_out_pc", out_pc, 32'd0);
    check_val("rst_out_imm", out_imm, 32'd0);
    check_val("rst_out_wr_reg_n", 32'(out_wr_reg_n), 32'd0);
    check_val("rst_out_illegal", 32'(out_is_illegal_ir), 32'd0);

    // Latency of the first instruction: two edges from push to out_valid
    out_ready = 1'b1;
    set_instr(0, 32'h1000);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check_val("lat_edge1_valid", 32'(out_valid), 32'd0);
    tick();
    check_val("lat_edge2_valid", 32'(out_valid), 32'd1);
    check_val("lat_rd", 32'(out_rd), 32'd1);
    check_val("lat_imm", out_imm, 32'd5);
    tick();

    // Every table entry once, back-to-back, EX always ready
    for (int i = 1; i < NT; i++) begin
      set_instr(i, 32'h2000 + 32'(i * 4));
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    check_val("table_drained", 32'(exp_q.size()), 32'd0);

    // Fill under backpressure: 4 queued plus 1 in the slot
    out_ready = 1'b0;
    base_acc = dut_acc;
    base_del = delivered;
    pc = 32'h0;
    set_instr(0, pc);
    in_valid = 1'b1;
    repeat (8) begin
      acc = in_ready;
      tick();
      if (acc) begin
        pc = pc + 32'd4;
        set_instr(int'(pc[6:2]) % NT, pc);
      end
    end
    check_val("full_accepted", 32'(dut_acc - base_acc), 32'd5);
    check_val("full_count", 32'(count), 32'd4);
    check_val("full_in_ready", 32'(in_ready), 32'd0);
    check_val("full_out_pc", out_pc, 32'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    check_val("full_delivered", 32'(delivered - base_del), 32'd5);
    check_val("full_last_pc", last_pc, 32'd16);
    check_val("full_drained", 32'(exp_q.size()), 32'd0);

    // Flush with three queued and a valid slot, push offered in same cycle
    out_ready = 1'b0;
    base_acc = dut_acc;
    pc = 32'h100;
    set_instr(7, pc);
    in_valid = 1'b1;
    guard = 0;
    while ((dut_acc - base_acc) < 4 && guard < 20) begin
      acc = in_ready;
      tick();
      guard++;
      if (acc) begin
        pc = pc + 32'd4;
        set_instr(8, pc);
      end
    end
    check_val("pre_flush_accepts", 32'(dut_acc - base_acc), 32'd4);
    check_val("pre_flush_count", 32'(count), 32'd3);
    check_val("pre_flush_valid", 32'(out_valid), 32'd1);
    set_instr(9, 32'h200);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    check_val("post_flush_count", 32'(count), 32'd0);
    check_val("post_flush_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    set_instr(12, 32'h300);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check_val("after_flush_valid", 32'(out_valid), 32'd1);
    check_val("after_flush_pc", out_pc, 32'h300);
    tick();
    check_val("after_flush_last_pc", last_pc, 32'h300);
    check_val("after_flush_drained", 32'(exp_q.size()), 32'd0);

    // Steady stream: one per cycle, pointers wrap several times
    base_del = delivered;
    out_ready = 1'b1;
    pc = 32'h4000;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_instr($urandom_range(0, NT - 1), pc);
      acc = in_ready;
      tick();
      if (acc) pc = pc + 32'd4;
      if (i >= 2) check_val("stream_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    repeat (4) tick();
    check_val("stream_delivered", 32'(delivered - base_del), 32'd20);
    check_val("stream_last_pc", last_pc, 32'h4000 + 32'd76);

    // Random traffic with random backpressure and occasional flush
    pc = 32'h8000;
    for (int i = 0; i < 400; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      set_instr($urandom_range(0, NT - 1), pc);
      pc = pc + 32'd4;
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    check_val("random_drained", 32'(exp_q.size()), 32'd0);
    check_val("random_count", 32'(count), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
